alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-step controller that drives the 4-bit ALU. It is the issuing side of the ALU's opcode/operand/result interface.
- Executes a short stored microprogram. Each step: select operands, issue an opcode to the ALU, capture alu_out into a scratch register.
- Replaces hand-sequenced multi-step ALU computations with a start/done handshake. Sits between the datapath control and an externally instantiated ALU.

Parameters:
- WIDTH, 4, ALU operand/result width.
- NREGS, 4, number of scratch registers (R0..R3).
- PROG_DEPTH, 8, microprogram entries; pc width is clog2(PROG_DEPTH).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- prog_we  in  1  program-memory write strobe.
- prog_addr  in  3  program write address.
- prog_data  in  16  instruction word.
- start  in  1  begin execution at pc=0.
- in_a  in  WIDTH  external operand A.
- in_b  in  WIDTH  external operand B.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  destination register of the final instruction.
- result_cout  out  1  carry flag of the final instruction.
- result_of  out  1  overflow flag of the final instruction (see Optional Feature).
- alu_opcode  out  4  opcode to the ALU.
- alu_a  out  WIDTH  operand A to the ALU.
- alu_b  out  WIDTH  operand B to the ALU.
- alu_cin  out  1  carry-in to the ALU.
- alu_out  in  WIDTH  ALU result, combinational from the alu_* outputs.
- alu_cout  in  1  ALU carry out.
- alu_of  in  1  ALU overflow.

Behaviour:
- Instruction fields: [15] last, [14:11] opcode, [10:8] srcA, [7:5] srcB, [4:3] dest, [2] cin, [1:0] reserved (ignored).
- Source select encoding: 0-3 = R0-R3, 4 = latched in_a, 5 = latched in_b, 6 = all zeros, 7 = all ones.
- Reset values: all outputs 0, scratch registers 0, program memory 0, pc 0, state IDLE.
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
- IDLE:
  - prog_we writes program memory.
  - start latches in_a/in_b, sets pc=0, moves to ISSUE.
  - If start and prog_we are both high, the write completes first and execution starts on the next edge.
- ISSUE: registers alu_opcode/alu_a/alu_b/alu_cin from the decoded instruction at pc; moves to CAPTURE.
- CAPTURE:
  - Writes alu_out into R[dest]; updates the flag registers.
  - If last=1 or pc==PROG_DEPTH-1, moves to DONE. A missing last bit therefore terminates at the final entry; pc never wraps.
  - Otherwise pc increments and the FSM returns to ISSUE.
- DONE:
  - done=1 for exactly one cycle.
  - result=R[dest of final instruction]; result, result_cout and result_of hold until the next start.
  - Returns to IDLE.
- busy=1 in ISSUE, CAPTURE and DONE.
- Latency: for an N-instruction program, done is high in the cycle after the 2N-th edge following the edge that samples start.
- While busy: start is ignored, prog_we is ignored (no memory change), and in_a/in_b changes have no effect.
- Reads from a scratch register return the value captured by any earlier instruction in the same run. There is no forwarding hazard, because capture precedes the next issue.
- Scratch registers persist across runs; only reset clears them.
- Reset mid-run: returns to IDLE immediately; done is not pulsed; all registers are cleared.
- Arithmetic belongs entirely to the ALU; the sequencer applies no width extension.

Optional Feature:
- Macro: ALU_SEQ_STICKY_FLAGS_EN.
- Defined: result_of and result_cout are the OR of alu_of/alu_cout over every CAPTURE in the run. Both are cleared on start.
- Undefined: both flags reflect only the final instruction.

Decomposition:
- Package alu_seq_pkg holds:
  - ALU opcode constants: OP_AND=0000, OP_OR=0001, OP_XOR=0010, OP_NOTSHR=0101, OP_ADD=1000, OP_ADDC=1001, OP_SUB=1010.
  - Source-select codes.
  - Instruction field bit positions.
  - FSM state encoding.
- Sub-module alu_seq_regfile holds the NREGS x WIDTH scratch registers: two combinational read ports, one write port, async active-low clear.

Test Plan:
- Program {XOR in_a,in_b->R0; AND in_a,in_b->R1; NOTSHR R1->R1; ADD R0,R1->R2 last}, in_a=0110, in_b=0011, start -> done at 8 edges, result=1011, result_cout=0, result_of=1.
- Single instruction {ADDC in_a,in_b, cin=1, last}, in_a=0111, in_b=0101 -> done at 2 edges, result=1101, result_of=1.
- Assert start again and issue prog_we during a run -> no restart, memory unchanged, exactly one done pulse.
- Program of 8 instructions with no last bit -> terminates after 16 edges, pc does not wrap, one done pulse.
- Assert rst_n=0 during CAPTURE of instruction 2 -> all outputs 0, state IDLE, no done pulse; rerun produces the correct result.
- With ALU_SEQ_STICKY_FLAGS_EN, program {ADD 0111+0101->R0; AND R0,R0->R1 last} -> result_of=1. Without the macro -> result_of=0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer.
//   - ALU opcode constants understood by the external ALU
//   - operand source-select codes
//   - instruction field positions and the decoded instruction struct
//   - sequencer FSM state encoding
// Optional feature macro: ALU_SEQ_STICKY_FLAGS_EN (consumed by alu_sequencer).
package alu_seq_pkg;

    localparam logic [3:0] OP_AND    = 4'b0000;
    localparam logic [3:0] OP_OR     = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_NOTSHR = 4'b0101;
    localparam logic [3:0] OP_ADD    = 4'b1000;
    localparam logic [3:0] OP_ADDC   = 4'b1001;
    localparam logic [3:0] OP_SUB    = 4'b1010;

    localparam logic [2:0] SRC_R0   = 3'd0;
    localparam logic [2:0] SRC_R1   = 3'd1;
    localparam logic [2:0] SRC_R2   = 3'd2;
    localparam logic [2:0] SRC_R3   = 3'd3;
    localparam logic [2:0] SRC_IN_A = 3'd4;
    localparam logic [2:0] SRC_IN_B = 3'd5;
    localparam logic [2:0] SRC_ZERO = 3'd6;
    localparam logic [2:0] SRC_ONES = 3'd7;

    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned RSVD_W   = 2;
    localparam int unsigned BIT_LAST = 15;
    localparam int unsigned OPC_MSB  = 14;
    localparam int unsigned OPC_LSB  = 11;
    localparam int unsigned SRCA_MSB = 10;
    localparam int unsigned SRCA_LSB = 8;
    localparam int unsigned SRCB_MSB = 7;
    localparam int unsigned SRCB_LSB = 5;
    localparam int unsigned DEST_MSB = 4;
    localparam int unsigned DEST_LSB = 3;
    localparam int unsigned BIT_CIN  = 2;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StCapture,
        StDone
    } state_e;

    typedef struct packed {
        logic       last;
        logic [3:0] opcode;
        logic [2:0] src_a;
        logic [2:0] src_b;
        logic [1:0] dest;
        logic       cin;
    } instr_t;

    // Takes the instruction word without its reserved low bits.
    function automatic instr_t decode(input logic [INSTR_W-1:RSVD_W] word);
        instr_t d;
        d.last   = word[BIT_LAST];
        d.opcode = word[OPC_MSB:OPC_LSB];
        d.src_a  = word[SRCA_MSB:SRCA_LSB];
        d.src_b  = word[SRCB_MSB:SRCB_LSB];
        d.dest   = word[DEST_MSB:DEST_LSB];
        d.cin    = word[BIT_CIN];
        return d;
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Scratch register file for the ALU sequencer.
// Ports:
//   clk, rst_n         clock, asynchronous active-low clear of all registers
//   we, waddr, wdata   single synchronous write port
//   raddr_a, rdata_a   combinational read port A
//   raddr_b, rdata_b   combinational read port B
module alu_seq_regfile #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NREGS = 4,
    localparam int unsigned AW   = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '{default: '0};
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Microprogrammed controller driving an external 4-bit ALU.
// A stored program is executed on start; each instruction takes an ISSUE cycle (operands and
// opcode registered onto alu_*) and a CAPTURE cycle (alu_out written to the destination register).
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   prog_we, prog_addr, prog_data    program memory write (accepted only while idle)
//   start, in_a, in_b                run request and external operands (latched on start)
//   busy, done                       run in progress / one-cycle completion pulse
//   result, result_cout, result_of   final instruction result and flags
//   alu_opcode, alu_a, alu_b, alu_cin   registered request to the ALU
//   alu_out, alu_cout, alu_of        combinational ALU response
// Optional feature macro: ALU_SEQ_STICKY_FLAGS_EN -- when defined, result_cout/result_of
// accumulate (OR) over every capture of a run and are cleared on start; otherwise they
// reflect only the final instruction.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned NREGS      = 4,
    parameter int unsigned PROG_DEPTH = 8,
    localparam int unsigned PC_W      = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               start,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               result_cout,
    output logic               result_of,
    output logic [3:0]         alu_opcode,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic               alu_cin,
    input  logic [WIDTH-1:0]   alu_out,
    input  logic               alu_cout,
    input  logic               alu_of
);

    localparam int unsigned AW        = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_DEPTH - 1);

    state_e           state;
    logic [PC_W-1:0]  pc;
    logic [WIDTH-1:0] lat_a;
    logic [WIDTH-1:0] lat_b;
    instr_t           prog_mem [PROG_DEPTH];
    instr_t           cur;
    logic             last_step;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;
    logic             unused_reserved;

    // Reserved instruction bits carry no meaning and are not stored.
    assign unused_reserved = ^prog_data[RSVD_W-1:0];

    // Memory is frozen while a run is in progress, so cur is stable across ISSUE and CAPTURE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_mem <= '{default: '0};
        end else if (prog_we && state == StIdle) begin
            prog_mem[prog_addr] <= decode(prog_data[INSTR_W-1:RSVD_W]);
        end
    end

    assign cur       = prog_mem[pc];
    assign last_step = cur.last || (pc == PC_LAST);

    alu_seq_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (state == StCapture),
        .waddr   (cur.dest[AW-1:0]),
        .wdata   (alu_out),
        .raddr_a (cur.src_a[AW-1:0]),
        .rdata_a (rd_a),
        .raddr_b (cur.src_b[AW-1:0]),
        .rdata_b (rd_b)
    );

    always_comb begin
        opnd_a = rd_a;
        case (cur.src_a)
            SRC_IN_A: opnd_a = lat_a;
            SRC_IN_B: opnd_a = lat_b;
            SRC_ZERO: opnd_a = '0;
            SRC_ONES: opnd_a = '1;
            default:  opnd_a = rd_a;
        endcase
    end

    always_comb begin
        opnd_b = rd_b;
        case (cur.src_b)
            SRC_IN_A: opnd_b = lat_a;
            SRC_IN_B: opnd_b = lat_b;
            SRC_ZERO: opnd_b = '0;
            SRC_ONES: opnd_b = '1;
            default:  opnd_b = rd_b;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            pc          <= '0;
            lat_a       <= '0;
            lat_b       <= '0;
            alu_opcode  <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_cin     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            result_cout <= 1'b0;
            result_of   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        lat_a <= in_a;
                        lat_b <= in_b;
                        pc    <= '0;
                        busy  <= 1'b1;
                        state <= StIssue;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
                        result_cout <= 1'b0;
                        result_of   <= 1'b0;
`endif
                    end
                end
                StIssue: begin
                    alu_opcode <= cur.opcode;
                    alu_a      <= opnd_a;
                    alu_b      <= opnd_b;
                    alu_cin    <= cur.cin;
                    state      <= StCapture;
                end
                StCapture: begin
`ifdef ALU_SEQ_STICKY_FLAGS_EN
                    result_cout <= result_cout | alu_cout;
                    result_of   <= result_of | alu_of;
`else
                    if (last_step) begin
                        result_cout <= alu_cout;
                        result_of   <= alu_of;
                    end
`endif
                    if (last_step) begin
                        // Final entry ends the run even without a last bit; pc never wraps.
                        done   <= 1'b1;
                        result <= alu_out;
                        state  <= StDone;
                    end else begin
                        pc    <= pc + 1'b1;
                        state <= StIssue;
                    end
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
    import alu_seq_pkg::*;

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        prog_we, start;
    logic [2:0]  prog_addr;
    logic [15:0] prog_data;
    logic [3:0]  in_a, in_b;
    logic        busy, done, result_cout, result_of, alu_cin, alu_cout, alu_of;
    logic [3:0]  result, alu_opcode, alu_a, alu_b, alu_out;

    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    // Reference 4-bit ALU: flags from true unsigned/signed range of the arithmetic.
    function automatic logic [5:0] alu_f(input logic [3:0] op, input logic [3:0] a,
                                         input logic [3:0] b, input logic cin);
        int ua, ub, sa, sb, ci, s, sr;
        logic [3:0] o, na;
        logic c, v;
        c = 1'b0; v = 1'b0; o = 4'd0;
        ua = int'(a); ub = int'(b);
        sa = (ua >= 8) ? ua - 16 : ua;
        sb = (ub >= 8) ? ub - 16 : ub;
        case (op)
            OP_AND: o = a & b;
            OP_OR:  o = a | b;
            OP_XOR: o = a ^ b;
            OP_NOTSHR: begin na = ~a; o = na >> 1; end
            OP_ADD, OP_ADDC: begin
                ci = (op == OP_ADDC) ? int'(cin) : 0;
                s = ua + ub + ci; sr = sa + sb + ci;
                o = 4'(s); c = (s > 15); v = (sr > 7) || (sr < -8);
            end
            OP_SUB: begin
                s = ua - ub; sr = sa - sb;
                o = 4'(s); c = (ua >= ub); v = (sr > 7) || (sr < -8);
            end
            default: o = 4'd0;
        endcase
        return {v, c, o};
    endfunction

    assign {alu_of, alu_cout, alu_out} = alu_f(alu_opcode, alu_a, alu_b, alu_cin);

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .in_a(in_a), .in_b(in_b), .busy(busy),
        .done(done), .result(result), .result_cout(result_cout), .result_of(result_of),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_cout(alu_cout), .alu_of(alu_of)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_mem [8];
    logic [3:0]  m_regs [4];
    int          m_phase = -1;   // edges since the accepted start, -1 when idle
    int          m_n = 1;        // instructions in the current run
    logic [3:0]  st_op [8], st_a [8], st_b [8], st_out [8];
    logic        st_cin [8], st_co [8], st_of [8], acc_co [8], acc_of [8];
    logic [3:0]  m_res = 0, e_op = 0, e_a = 0, e_b = 0;
    logic        m_co = 0, m_of = 0, e_cin = 0;

    initial begin
        foreach (m_mem[i]) m_mem[i] = '0;
        foreach (m_regs[i]) m_regs[i] = '0;
    end

    function automatic logic [3:0] srcv(input logic [2:0] sel, input logic [3:0] la,
                                        input logic [3:0] lb);
        if (sel < 3'd4) return m_regs[sel[1:0]];
        if (sel == 3'd4) return la;
        if (sel == 3'd5) return lb;
        if (sel == 3'd6) return 4'h0;
        return 4'hf;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            foreach (m_regs[i]) m_regs[i] = '0;
            m_phase = -1; m_res = 0; m_co = 0; m_of = 0;
            e_op = 0; e_a = 0; e_b = 0; e_cin = 0;
        end else if (m_phase < 0) begin
            if (prog_we) m_mem[prog_addr] = prog_data;
            if (start) begin
                logic co_acc, of_acc;
                logic [5:0] r;
                co_acc = 0; of_acc = 0;
                for (int i = 0; i < 8; i++) begin
                    st_op[i]  = m_mem[i][14:11];
                    st_a[i]   = srcv(m_mem[i][10:8], in_a, in_b);
                    st_b[i]   = srcv(m_mem[i][7:5], in_a, in_b);
                    st_cin[i] = m_mem[i][2];
                    r = alu_f(st_op[i], st_a[i], st_b[i], st_cin[i]);
                    st_out[i] = r[3:0]; st_co[i] = r[4]; st_of[i] = r[5];
                    m_regs[m_mem[i][4:3]] = r[3:0];
                    co_acc |= r[4]; of_acc |= r[5];
                    acc_co[i] = co_acc; acc_of[i] = of_acc;
                    m_n = i + 1;
                    if (m_mem[i][15]) break;
                end
                m_phase = 0;
                if (STICKY) begin m_co = 0; m_of = 0; end
            end
        end else begin
            m_phase++;
            if (m_phase == 2 * m_n + 1) begin
                m_phase = -1;
            end else if (m_phase % 2 == 1) begin
                e_op = st_op[(m_phase - 1) / 2]; e_a = st_a[(m_phase - 1) / 2];
                e_b = st_b[(m_phase - 1) / 2]; e_cin = st_cin[(m_phase - 1) / 2];
            end else begin
                if (STICKY) begin
                    m_co = acc_co[m_phase / 2 - 1]; m_of = acc_of[m_phase / 2 - 1];
                end
                if (m_phase == 2 * m_n) begin
                    m_res = st_out[m_n - 1];
                    if (!STICKY) begin m_co = st_co[m_n - 1]; m_of = st_of[m_n - 1]; end
                end
            end
        end
    end

    // Every-cycle compare against the model.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("busy", busy, (m_phase >= 0));
            check("done", done, (m_phase == 2 * m_n));
            check("result", result, m_res);
            check("result_cout", result_cout, m_co);
            check("result_of", result_of, m_of);
            check("alu_opcode", alu_opcode, e_op);
            check("alu_a", alu_a, e_a);
            check("alu_b", alu_b, e_b);
            check("alu_cin", alu_cin, e_cin);
        end
    end

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    // ---------------- stimulus helpers ----------------
    function automatic logic [15:0] mk(input bit last, input logic [3:0] op, input logic [2:0] sa,
                                       input logic [2:0] sb, input logic [1:0] d, input bit cin);
        return {last, op, sa, sb, d, cin, 2'b00};
    endfunction

    function automatic logic [15:0] rand_instr(input bit allow_last);
        logic [3:0] ops [7];
        ops = '{OP_AND, OP_OR, OP_XOR, OP_NOTSHR, OP_ADD, OP_ADDC, OP_SUB};
        return mk(allow_last && ($urandom_range(0, 3) == 0), ops[$urandom_range(0, 6)],
                  3'($urandom), 3'($urandom), 2'($urandom), 1'($urandom)) | 16'($urandom_range(0, 3));
    endfunction

    task automatic wr(input int addr, input logic [15:0] d);
        @(negedge clk); prog_we = 1; prog_addr = 3'(addr); prog_data = d;
        @(negedge clk); prog_we = 0;
    endtask

    task automatic load_main();
        wr(0, mk(0, OP_XOR, 3'd4, 3'd5, 2'd0, 0));
        wr(1, mk(0, OP_AND, 3'd4, 3'd5, 2'd1, 0));
        wr(2, mk(0, OP_NOTSHR, 3'd1, 3'd6, 2'd1, 0));
        wr(3, mk(1, OP_ADD, 3'd0, 3'd1, 2'd2, 0));
    endtask

    // Returns the number of edges after the start-sampling edge until done is seen.
    task automatic run(input logic [3:0] a, input logic [3:0] b, input bit noise, output int edges);
        @(negedge clk); in_a = a; in_b = b; start = 1;
        @(posedge clk);
        edges = 0;
        while (edges < 64) begin
            @(negedge clk);
            if (done) break;
            start = noise;
            if (noise) begin
                prog_we = 1; prog_addr = 3'($urandom); prog_data = 16'($urandom);
                in_a = 4'($urandom); in_b = 4'($urandom);
            end
            @(posedge clk); edges++;
        end
        start = 0; prog_we = 0;
        @(posedge clk);
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_busy"}, busy, 0);      check({tag, "_done"}, done, 0);
        check({tag, "_result"}, result, 0);  check({tag, "_cout"}, result_cout, 0);
        check({tag, "_of"}, result_of, 0);   check({tag, "_opc"}, alu_opcode, 0);
        check({tag, "_a"}, alu_a, 0);        check({tag, "_b"}, alu_b, 0);
        check({tag, "_cin"}, alu_cin, 0);
    endtask

    initial begin
        int e, d0;
        start = 0; prog_we = 0; prog_addr = 0; prog_data = 0; in_a = 0; in_b = 0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1;

        // Four-step program: (6^3) + ((~(6&3))>>1) = 5 + 6 = 11, signed overflow.
        load_main();
        run(4'b0110, 4'b0011, 0, e);
        check("main_edges", e, 8);
        check("main_result", result, 4'b1011);
        check("main_cout", result_cout, 0);
        check("main_of", result_of, 1);

        // Single ADDC with carry-in: 7+5+1 = 13.
        wr(0, mk(1, OP_ADDC, 3'd4, 3'd5, 2'd3, 1));
        run(4'b0111, 4'b0101, 0, e);
        check("addc_edges", e, 2);
        check("addc_result", result, 4'b1101);
        check("addc_of", result_of, 1);
        check("addc_cout", result_cout, 0);

        // start/prog_we/in_* noise while busy must be ignored.
        load_main();
        d0 = done_cnt;
        run(4'b0110, 4'b0011, 1, e);
        repeat (3) @(negedge clk);
        check("noise_edges", e, 8);
        check("noise_result", result, 4'b1011);
        check("noise_done_pulses", done_cnt - d0, 1);
        run(4'b0110, 4'b0011, 0, e);
        check("noise_mem_kept", e, 8);

        // Eight entries without a last bit: stop at the final entry.
        for (int i = 0; i < 8; i++) wr(i, rand_instr(0));
        d0 = done_cnt;
        run(4'($urandom), 4'($urandom), 0, e);
        repeat (3) @(negedge clk);
        check("nolast_edges", e, 16);
        check("nolast_done_pulses", done_cnt - d0, 1);

        // Flag accumulation: ADD 7+5 overflows, final AND does not.
        wr(0, mk(0, OP_ADD, 3'd4, 3'd5, 2'd0, 0));
        wr(1, mk(1, OP_AND, 3'd0, 3'd0, 2'd1, 0));
        run(4'b0111, 4'b0101, 0, e);
        check("sticky_result", result, 4'b1100);
        check("sticky_of", result_of, STICKY ? 1 : 0);

        // Randomized programs and operands, alternating with busy-time noise.
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < 8; i++) wr(i, rand_instr(1));
            run(4'($urandom), 4'($urandom), it[0], e);
            check("rand_edges", e, 2 * m_n);
        end

        // Reset during CAPTURE of the second instruction.
        load_main();
        d0 = done_cnt;
        @(negedge clk); in_a = 4'b0110; in_b = 4'b0011; start = 1;
        @(posedge clk);
        @(negedge clk); start = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 0;
        #1 chk_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (4) @(negedge clk);
        check("midrst_no_done", done_cnt - d0, 0);
        // R0 must have been cleared: 0 + 1111.
        wr(0, mk(1, OP_ADD, 3'd0, 3'd7, 2'd3, 0));
        run(4'b0000, 4'b0000, 0, e);
        check("midrst_regs_clear", result, 4'b1111);
        load_main();
        run(4'b0110, 4'b0011, 0, e);
        check("rerun_edges", e, 8);
        check("rerun_result", result, 4'b1011);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
